clk_div_ctrl: RTL

Programmable clock-divider controller that generates a divided clock O_CLK from I_CLK.
- Divide ratio is configurable at run time over a valid/ready handshake.
- Ratio changes and stop requests take effect only at period boundaries, so O_CLK never glitches or truncates a period.
- Sits between the board-level control logic and every block clocked or paced by the divided clock.

---
 rtl/clk_div_ctrl_if.sv | 9 +
 rtl/clk_div_ctrl.sv | 80 ++++++++
 2 files changed

// File: rtl/clk_div_ctrl_if.sv
// clk_div_ctrl_if: ratio configuration handshake (valid/ready plus reject pulse); master drives cfg_valid/cfg_div, slave returns cfg_ready/cfg_err
interface clk_div_ctrl_if #(parameter int W = 16);
  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready;
  logic         cfg_err;
  modport master (output cfg_valid, cfg_div, input cfg_ready, cfg_err);
  modport slave (input cfg_valid, cfg_div, output cfg_ready, cfg_err);
endinterface

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: glitch-free programmable divider; ports I_CLK/rst, en run request, cfg handshake, registered O_CLK/tick/busy
module clk_div_ctrl #(
  parameter int W           = 16,
  parameter int DEFAULT_DIV = 20
) (
  input  logic          I_CLK,
  input  logic          rst,
  input  logic          en,
  clk_div_ctrl_if.slave cfg,
  output logic          O_CLK,
  output logic          tick,
  output logic          busy
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [W-1:0] DEF_DIV = W'(DEFAULT_DIV);
  logic [1:0]   state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d, cur_div_q, cur_div_d, pend_q, pend_d;
  logic         pend_vld_q, pend_vld_d, ready_q, err_q, err_d;
  logic         o_clk_q, o_clk_d, tick_q, tick_d, busy_q, busy_d;
  logic         run, wrap, acc;
  always_comb begin
    run        = state_q != IDLE;
    wrap       = run && cnt_q == cur_div_q - W'(1);
    acc        = cfg.cfg_valid && ready_q;
    err_d      = acc && cfg.cfg_div < W'(2);
    state_d    = !run ? (en ? RUN : IDLE) : en ? RUN : wrap ? IDLE : DRAIN;
    cnt_d      = (wrap || !run) ? '0 : cnt_q + W'(1);
    cur_div_d  = cur_div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (wrap && pend_vld_q) begin
      cur_div_d  = pend_q;
      pend_vld_d = 1'b0;
    end
    if (acc && !err_d) begin
      pend_d     = cfg.cfg_div;
      pend_vld_d = 1'b1;
    end
    // Outside a running period there is no boundary to wait for, so apply at once
    if (pend_vld_d && (!run || state_d == IDLE)) begin
      cur_div_d  = pend_d;
      pend_vld_d = 1'b0;
    end
    busy_d  = state_d != IDLE;
    o_clk_d = busy_d && cnt_d < (cur_div_d >> 1);
    tick_d  = busy_d && cnt_d == cur_div_d - W'(1);
  end
  always_ff @(posedge I_CLK or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cur_div_q  <= DEF_DIV;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ready_q    <= 1'b1;
      err_q      <= 1'b0;
      o_clk_q    <= 1'b0;
      tick_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ready_q    <= !pend_vld_d;
      err_q      <= err_d;
      o_clk_q    <= o_clk_d;
      tick_q     <= tick_d;
      busy_q     <= busy_d;
    end
  end
  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_err   = err_q;
  assign O_CLK         = o_clk_q;
  assign tick          = tick_q;
  assign busy          = busy_q;
endmodule
